// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter with a valid/ready load, start/pause and a
//            one-cycle terminal-count pulse. Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN
//            enables periodic reload of the last loaded value.
// Revision : 1.0
// ============================================================================
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_load;
  logic [WIDTH-1:0] w_term_q;
  logic             w_term_stay;

  assign load_ready = (r_state != S_RUN);
  assign busy       = (r_state == S_RUN);
  assign Q          = r_q;
  assign done       = r_done;
  assign w_load     = load_valid && load_ready;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_reload <= '0;
    end else if (w_load) begin
      r_reload <= load_value;
    end
  end

  // A zero reload value falls back to the one-shot terminal behaviour.
  assign w_term_q    = r_reload;
  assign w_term_stay = (r_reload != '0);
`else
  assign w_term_q    = '0;
  assign w_term_stay = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_q_nxt     = load_value;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // A load on the same edge as start takes priority.
        if (w_load) begin
          w_q_nxt = load_value;
        end else if (start) begin
          if (r_q != '0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (!pause) begin
          if (r_q == WIDTH'(1)) begin
            w_done_nxt = 1'b1;
            w_q_nxt    = w_term_q;
            if (!w_term_stay) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_q_nxt = r_q - WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_q_nxt     = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
